// File: rtl/crc_32_byte_package.sv
// Shared definitions for the Ethernet FCS checker.
//   CRC_POLY / CRC_INITIAL_VALUE / CRC_RESIDUE : MSB-first CRC-32 constants.
//     The FCS bytes are folded into the register, and there is no final
//     inversion or reflection. A good frame therefore leaves CRC_RESIDUE.
//   fcs_state_t      : receive state machine encoding
//   bit_reverse_byte : Ethernet sends bits LSB first, so each byte is
//                      reversed before it enters the MSB-first register
package crc_32_byte_package;

    localparam logic [31:0] CRC_POLY          = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INITIAL_VALUE = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE       = 32'hC704_DD7B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } fcs_state_t;

    function automatic logic [7:0] bit_reverse_byte(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fcs_strip_delay.sv
// Four-byte delay line that strips the trailing FCS from a frame.
//   clk, rst   : clock and synchronous active-high reset
//   push       : an accepted byte that takes part in the output stream
//   start      : the pushed byte is the first of a new frame. Any bytes
//                still held from an earlier frame are discarded.
//   last       : the pushed byte ends the frame
//   in_data    : byte being pushed
//   out_*      : stripped frame, registered one cycle after the push
//                that releases each byte
module fcs_strip_delay (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       start,
    input  logic       last,
    input  logic [7:0] in_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_sof,
    output logic       out_eof
);

    logic [7:0] sr_p0 [4];
    logic [2:0] occ_p0;
    logic       first_p0;
    logic       emit;

    logic [7:0] data_p1;
    logic       vld_p1;
    logic       sof_p1;
    logic       eof_p1;

    // The oldest byte leaves only after four bytes of the same frame are already held.
    assign emit = push && !start && (occ_p0 == 3'd4);

    // ---- stage p0: byte storage and occupancy ----
    always_ff @(posedge clk) begin
        if (push) begin
            sr_p0[0] <= in_data;
            sr_p0[1] <= sr_p0[0];
            sr_p0[2] <= sr_p0[1];
            sr_p0[3] <= sr_p0[2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_p0   <= 3'd0;
            first_p0 <= 1'b0;
        end else if (push) begin
            if (start) begin
                occ_p0   <= last ? 3'd0 : 3'd1;
                first_p0 <= !last;
            end else if (last) begin
                occ_p0   <= 3'd0;
                first_p0 <= 1'b0;
            end else begin
                if (occ_p0 != 3'd4) begin
                    occ_p0 <= occ_p0 + 3'd1;
                end
                if (emit) begin
                    first_p0 <= 1'b0;
                end
            end
        end
    end

    // ---- stage p1: registered output ----
    always_ff @(posedge clk) begin
        if (rst) begin
            data_p1 <= 8'd0;
            vld_p1  <= 1'b0;
            sof_p1  <= 1'b0;
            eof_p1  <= 1'b0;
        end else begin
            vld_p1 <= emit;
            sof_p1 <= emit && first_p0;
            eof_p1 <= emit && last;
            if (emit) begin
                data_p1 <= sr_p0[3];
            end
        end
    end

    assign out_data  = data_p1;
    assign out_valid = vld_p1;
    assign out_sof   = sof_p1;
    assign out_eof   = eof_p1;

endmodule

// File: rtl/eth_fcs_checker.sv
// Ethernet frame checker. It verifies the CRC-32 FCS and the frame length,
// and it forwards the frame with the 4 FCS bytes removed.
//   clk, rst                      : clock and synchronous active-high reset
//   rx_data/rx_valid/rx_sof/rx_eof: input byte stream. Gaps are allowed.
//   out_data/out_valid/out_sof/out_eof : stripped frame
//   frame_done                    : one-cycle verdict strobe
//   frame_ok/crc_err/len_err/abort_err : verdict, held until the next strobe
//   frame_len                     : byte count including the FCS. It
//                                   saturates at 2047 and is held.
module eth_fcs_checker
    import crc_32_byte_package::*;
#(
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_sof,
    input  logic        rx_eof,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        crc_err,
    output logic        len_err,
    output logic        abort_err,
    output logic [10:0] frame_len
);

    localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_BYTES);
    localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_BYTES);

    function automatic logic [31:0] crc_byte_update(input logic [31:0] c_in,
                                                    input logic [7:0]  b);
        logic [31:0] c;
        c = c_in ^ {bit_reverse_byte(b), 24'h0};
        for (int i = 0; i < 8; i++) begin
            c = c[31] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

    fcs_state_t  state_p0, state_d;
    logic [31:0] crc_p0;
    logic [10:0] cnt_p0;

    logic        start, accept, abort, finish, push;
    logic [10:0] cnt_inc, cnt_next;
    logic        over;
    logic [31:0] crc_next;
    logic        len_bad;

    assign start    = rx_valid && rx_sof;
    assign cnt_inc  = (cnt_p0 == 11'h7FF) ? cnt_p0 : cnt_p0 + 11'd1;
    assign over     = cnt_inc > MAX_LEN;
    assign cnt_next = start ? 11'd1 : cnt_inc;
    assign crc_next = crc_byte_update(start ? CRC_INITIAL_VALUE : crc_p0, rx_data);
    assign len_bad  = (cnt_next < MIN_LEN) || (cnt_next > MAX_LEN);

    always_comb begin
        state_d = state_p0;
        accept  = 1'b0;
        abort   = 1'b0;
        finish  = 1'b0;
        push    = 1'b0;
        unique case (state_p0)
            ST_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    push   = 1'b1;
                    if (rx_eof) begin
                        finish = 1'b1;
                    end else begin
                        state_d = ST_RECV;
                    end
                end
            end
            ST_RECV, ST_DROP: begin
                if (rx_valid) begin
                    accept = 1'b1;
                    if (rx_sof) begin
                        // The new frame replaces the unfinished one. If this
                        // byte also carries eof, only the abort is reported.
                        abort   = 1'b1;
                        push    = 1'b1;
                        state_d = rx_eof ? ST_IDLE : ST_RECV;
                    end else if (rx_eof) begin
                        finish  = 1'b1;
                        push    = (state_p0 == ST_RECV) && !over;
                        state_d = ST_IDLE;
                    end else if (state_p0 == ST_RECV) begin
                        if (over) begin
                            state_d = ST_DROP;
                        end else begin
                            push = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---- stage p0: state, CRC and count; verdict registered alongside ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0   <= ST_IDLE;
            crc_p0     <= CRC_INITIAL_VALUE;
            cnt_p0     <= 11'd0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            crc_err    <= 1'b0;
            len_err    <= 1'b0;
            abort_err  <= 1'b0;
            frame_len  <= 11'd0;
        end else begin
            state_p0   <= state_d;
            frame_done <= finish || abort;
            if (accept) begin
                crc_p0 <= crc_next;
                cnt_p0 <= cnt_next;
            end
            if (abort) begin
                frame_ok  <= 1'b0;
                crc_err   <= 1'b0;
                len_err   <= 1'b0;
                abort_err <= 1'b1;
                frame_len <= cnt_p0;
            end else if (finish) begin
                frame_ok  <= (crc_next == CRC_RESIDUE) && !len_bad;
                crc_err   <= crc_next != CRC_RESIDUE;
                len_err   <= len_bad;
                abort_err <= 1'b0;
                frame_len <= cnt_next;
            end
        end
    end

    fcs_strip_delay u_strip (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .start     (start),
        .last      (rx_eof),
        .in_data   (rx_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eof   (out_eof)
    );

endmodule

// File: tb/tb_eth_fcs_checker.sv
module tb_eth_fcs_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic       rx_sof = 1'b0;
    logic       rx_eof = 1'b0;

    logic [7:0]  a_out_data, b_out_data;
    logic        a_out_valid, a_out_sof, a_out_eof, b_out_valid, b_out_sof, b_out_eof;
    logic        a_frame_done, a_frame_ok, a_crc_err, a_len_err, a_abort_err;
    logic        b_frame_done, b_frame_ok, b_crc_err, b_len_err, b_abort_err;
    logic [10:0] a_frame_len, b_frame_len;

    always #5 clk = ~clk;

    eth_fcs_checker dut_a (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_sof(rx_sof), .rx_eof(rx_eof),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_sof(a_out_sof), .out_eof(a_out_eof),
        .frame_done(a_frame_done), .frame_ok(a_frame_ok), .crc_err(a_crc_err),
        .len_err(a_len_err), .abort_err(a_abort_err), .frame_len(a_frame_len)
    );

    eth_fcs_checker #(.MIN_FRAME_BYTES(4)) dut_b (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_sof(rx_sof), .rx_eof(rx_eof),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_sof(b_out_sof), .out_eof(b_out_eof),
        .frame_done(b_frame_done), .frame_ok(b_frame_ok), .crc_err(b_crc_err),
        .len_err(b_len_err), .abort_err(b_abort_err), .frame_len(b_frame_len)
    );

    typedef logic [7:0] bq_t[$];
    typedef struct {
        bit abort;
        bit crc_bad;
        int len;
    } verdict_t;

    logic [9:0] oq_a[$];
    logic [9:0] oq_b[$];
    verdict_t   vq_a[$];
    verdict_t   vq_b[$];
    int         n_vec = 0;
    int         n_miscompare = 0;
    bit         gaps = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reflected (LSB-first) CRC-32 reference. A frame with a correct FCS
    // leaves 0xDEBB20E3 in this form.
    function automatic logic [31:0] crc_refl(input bq_t d, input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, d[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return c;
    endfunction

    function automatic bq_t with_fcs(input bq_t p);
        bq_t         r;
        logic [31:0] f;
        r = p;
        f = ~crc_refl(p, p.size());
        r.push_back(f[7:0]);
        r.push_back(f[15:8]);
        r.push_back(f[23:16]);
        r.push_back(f[31:24]);
        return r;
    endfunction

    task automatic check_verdict(input string tag, input int minb, input verdict_t v,
                                 input logic ok, input logic ce, input logic le,
                                 input logic ae, input logic [10:0] fl);
        bit exp_le;
        exp_le = (v.len < minb) || (v.len > 1518);
        check({tag, "_abort_err"}, 32'(ae), 32'(v.abort));
        if (!v.abort) begin
            check({tag, "_crc_err"}, 32'(ce), 32'(v.crc_bad));
            check({tag, "_len_err"}, 32'(le), 32'(exp_le));
            check({tag, "_frame_len"}, 32'(fl), 32'((v.len > 2047) ? 2047 : v.len));
        end
        check({tag, "_frame_ok"}, 32'(ok), 32'(!v.abort && !v.crc_bad && !exp_le));
    endtask

    // Scoreboard: pushes the expected stripped bytes and verdict of the first n bytes of fr.
    task automatic expect_frame(input bq_t fr, input int n, input bit complete, input bit abort);
        int         lim;
        logic [9:0] e;
        verdict_t   v;
        lim = (n < 1518) ? n : 1518;
        for (int i = 0; i < lim - 4; i++) begin
            e = {complete && (n <= 1518) && (i == lim - 5), i == 0, fr[i]};
            oq_a.push_back(e);
            oq_b.push_back(e);
        end
        v.abort   = abort;
        v.len     = n;
        v.crc_bad = crc_refl(fr, n) != 32'hDEBB_20E3;
        if (complete || abort) begin
            vq_a.push_back(v);
            vq_b.push_back(v);
        end
    endtask

    task automatic drive_byte(input logic [7:0] d, input bit sof, input bit eof);
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
                rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_data = 8'($urandom);
            end
        end
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_sof = sof; rx_eof = eof; rx_data = d;
    endtask

    task automatic go_idle(input int cyc);
        repeat (cyc) begin
            @(posedge clk); #1;
            rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
        end
    endtask

    // Drives the first n bytes of fr. n < fr.size() leaves the frame unfinished.
    task automatic send(input bq_t fr, input int n, input bit abort);
        expect_frame(fr, n, n == fr.size(), abort);
        for (int i = 0; i < n; i++) begin
            drive_byte(fr[i], i == 0, (i == n - 1) && (n == fr.size()));
        end
    endtask

    task automatic apply_reset(input int cyc);
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rst = 1'b1;
        repeat (cyc) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_a_out", {21'h0, a_out_valid, a_out_sof, a_out_eof, a_out_data}, 32'h0);
            check("rst_a_verdict", {27'h0, a_frame_done, a_frame_ok, a_crc_err, a_len_err, a_abort_err}, 32'h0);
            check("rst_a_len", 32'(a_frame_len), 32'h0);
            check("rst_b_out", {21'h0, b_out_valid, b_out_sof, b_out_eof, b_out_data}, 32'h0);
            check("rst_b_verdict", {27'h0, b_frame_done, b_frame_ok, b_crc_err, b_len_err, b_abort_err}, 32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (a_out_valid) begin
            if (oq_a.size() == 0) check("a_out_extra", 32'(oq_a.size()), 32'd1);
            else check("a_out", {22'h0, a_out_eof, a_out_sof, a_out_data}, 32'(oq_a.pop_front()));
        end
        if (b_out_valid) begin
            if (oq_b.size() == 0) check("b_out_extra", 32'(oq_b.size()), 32'd1);
            else check("b_out", {22'h0, b_out_eof, b_out_sof, b_out_data}, 32'(oq_b.pop_front()));
        end
        if (a_frame_done) begin
            if (vq_a.size() == 0) check("a_done_extra", 32'(vq_a.size()), 32'd1);
            else check_verdict("a", 64, vq_a.pop_front(), a_frame_ok, a_crc_err, a_len_err, a_abort_err, a_frame_len);
        end
        if (b_frame_done) begin
            if (vq_b.size() == 0) check("b_done_extra", 32'(vq_b.size()), 32'd1);
            else check_verdict("b", 4, vq_b.pop_front(), b_frame_ok, b_crc_err, b_len_err, b_abort_err, b_frame_len);
        end
    end

    initial begin
        bq_t f_std, f_arp, f_bad, f_junk, f_big, f_one, p;

        apply_reset(2);

        // "123456789" with its FCS
        f_std = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                  8'h26, 8'h39, 8'hF4, 8'hCB};
        send(f_std, 13, 1'b0);
        go_idle(3);

        // bytes without sof while idle are ignored
        for (int i = 0; i < 6; i++) drive_byte(8'($urandom), 1'b0, i == 5);
        go_idle(2);

        // broadcast ARP request, padded to 60 bytes plus FCS
        p = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
              8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
              8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hC0, 8'hA8, 8'h00, 8'h01,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h02};
        while (p.size() < 60) p.push_back(8'h00);
        f_arp = with_fcs(p);
        gaps = 1'b1;
        send(f_arp, 64, 1'b0);
        go_idle(2);
        f_bad = f_arp;
        f_bad[20] = f_bad[20] ^ 8'h01;
        send(f_bad, 64, 1'b0);
        go_idle(2);

        // sof on byte 30 of an unfinished frame, then a good frame
        p = {};
        for (int i = 0; i < 60; i++) p.push_back(8'($urandom));
        f_junk = with_fcs(p);
        send(f_junk, 29, 1'b1);
        send(f_arp, 64, 1'b0);
        go_idle(2);
        gaps = 1'b0;

        // oversize frame with a correct FCS
        p = {};
        for (int i = 0; i < 1596; i++) p.push_back(8'($urandom));
        f_big = with_fcs(p);
        send(f_big, 1600, 1'b0);
        go_idle(2);

        // reset ten bytes into a frame, then a good frame right away
        send(f_junk, 10, 1'b0);
        apply_reset(2);
        send(f_arp, 64, 1'b0);
        go_idle(2);

        // sof and eof on the same byte
        f_one = '{8'h55};
        send(f_one, 1, 1'b0);
        go_idle(2);

        for (int i = 0; i < 200; i++) begin
            if (oq_a.size() == 0 && oq_b.size() == 0 && vq_a.size() == 0 && vq_b.size() == 0) break;
            @(posedge clk);
        end
        check("drain_a_out", 32'(oq_a.size()), 32'd0);
        check("drain_b_out", 32'(oq_b.size()), 32'd0);
        check("drain_a_done", 32'(vq_a.size()), 32'd0);
        check("drain_b_done", 32'(vq_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule

// File: doc/eth_fcs_checker.md
ETH_FCS_CHECKER -- requirements
Module: eth_fcs_checker

Interface
REQ-001 SHALL have parameter MIN_FRAME_BYTES, default 64: minimum legal frame length in bytes, FCS included.
REQ-002 SHALL have parameter MAX_FRAME_BYTES, default 1518: maximum legal frame length in bytes, FCS included.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx_data  input  8  received byte, destination MAC first, FCS last.
REQ-006 SHALL have port rx_valid  input  1  rx_data/rx_sof/rx_eof qualifier; gaps allowed mid-frame.
REQ-007 SHALL have port rx_sof  input  1  first byte of frame (valid only with rx_valid).
REQ-008 SHALL have port rx_eof  input  1  last FCS byte of frame (valid only with rx_valid).
REQ-009 SHALL have ports out_data/out_valid/out_sof/out_eof  output  8/1/1/1  frame with 4 FCS bytes stripped.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse: frame verdict valid.
REQ-011 SHALL have ports frame_ok/crc_err/len_err/abort_err  output  1 each  verdict flags, held until next frame_done.
REQ-012 SHALL have port frame_len  output  11  byte count of last frame incl. FCS, saturating at 2047, held.

Function
REQ-013 SHALL run states IDLE, RECV, DROP; IDLE->RECV on rx_valid&rx_sof; RECV->IDLE on rx_valid&rx_eof; RECV->DROP when count exceeds MAX_FRAME_BYTES; DROP->IDLE on rx_valid&rx_eof.
REQ-014 SHALL ignore rx_valid bytes without rx_sof while IDLE.
REQ-015 SHALL reload CRC to 0xFFFFFFFF on sof, then per accepted byte: XOR bit-reversed byte into bits 31:24, 8 MSB-first shifts with polynomial 0x04C11DB7.
REQ-016 SHALL include FCS bytes in CRC and declare crc good iff the register equals residue 0xC704DD7B after the eof byte.
REQ-017 SHALL count accepted bytes from 1 at sof; len_err = count < MIN_FRAME_BYTES or count > MAX_FRAME_BYTES.
REQ-018 SHALL pulse frame_done the cycle after the accepted eof byte; frame_ok = crc good & !len_err & !abort_err.
REQ-019 SHALL treat rx_sof while RECV/DROP as abort: frame_done next cycle with abort_err=1, frame_ok=0, and the new frame starts with that byte.
REQ-020 SHALL treat sof and eof on the same byte as a 1-byte frame (len_err=1, crc_err per residue).
REQ-021 SHALL hold the last 4 accepted bytes in a delay line; each accepted byte beyond the 4th emits the oldest byte, registered, one cycle later.
REQ-022 SHALL flag out_sof on the first emitted byte and out_eof on the byte emitted in response to rx_eof; frames of <=4 bytes emit nothing.
REQ-023 SHALL stop emitting output bytes in DROP; abort SHALL flush the delay line without out_eof.
REQ-024 SHALL not stall: no backpressure input, one byte per cycle sustained.

Reset
REQ-025 SHALL on rst: state IDLE, CRC 0xFFFFFFFF, count 0, delay line empty, all outputs 0.
REQ-026 SHALL, on rst mid-frame, discard the frame with no frame_done and accept a new sof the cycle after rst deasserts.

Structure
REQ-027 SHALL place CRC_POLY, CRC_INITIAL_VALUE, CRC_RESIDUE, state enum and the bit-reverse byte function in shared package crc_32_byte_package.
REQ-028 SHALL implement the 4-byte delay line as sub-module fcs_strip_delay; CRC update stays inline.

Verification
REQ-029 SHALL check: MIN_FRAME_BYTES=4, bytes "123456789" then 26 39 F4 CB with sof/eof -> frame_done, frame_ok=1, frame_len=13, out emits 31..39 with out_eof on 0x39.
REQ-030 SHALL check: same stream, default parameters -> crc_err=0, len_err=1, frame_ok=0.
REQ-031 SHALL check: 64-byte broadcast ARP frame with correct FCS, random rx_valid gaps -> frame_ok=1, 60 output bytes; flip bit 0 of byte 20 -> crc_err=1.
REQ-032 SHALL check: sof at byte 30 of a frame -> abort_err=1 pulse, following 64-byte good frame -> frame_ok=1.
REQ-033 SHALL check: 1600-byte frame -> output stops after byte 1514, frame_len=1600, len_err=1; rst at byte 10 of a frame -> no frame_done.
